// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the external asynchronous SRAM controller.
// Holds the access FSM state type, wait counter width and strobe length helper.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam int WS_W = 4;

    // Strobe width in cycles for a given wait-state setting.
    function automatic int unsigned strobe_len(input int unsigned ws);
        return ws + 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Host-side request/acknowledge bus of the SRAM controller.
// master: req, wea, addra, dina, wp out; douta, ack, busy in. slave: mirrored.
interface sram_ctrl_if #(
    parameter int HOST_AW = 16,
    parameter int DW      = 8
);
    logic               req;
    logic               wea;
    logic [HOST_AW-1:0] addra;
    logic [DW-1:0]      dina;
    logic               wp;
    logic [DW-1:0]      douta;
    logic               ack;
    logic               busy;

    modport master (
        output req, wea, addra, dina, wp,
        input  douta, ack, busy
    );

    modport slave (
        input  req, wea, addra, dina, wp,
        output douta, ack, busy
    );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: req/ack host bus -> SETUP/STROBE/HOLD pin timing.
// Ports: clka, reset (async, active high), host (sram_ctrl_if.slave),
// SRAM_ADDR, SRAM_DATA (tri-state), SRAM_WE_n, SRAM_OE_n.
// Optional write protect: define SRAM_CTRL_WP_EN to suppress writes taken with wp=1.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int                           HOST_AW     = 16,
    parameter int                           SRAM_AW     = 21,
    parameter int                           DW          = 8,
    parameter int unsigned                  WAIT_STATES = 1,
    parameter logic [SRAM_AW-HOST_AW-1:0]   PAGE        = '0
) (
    input  logic               clka,
    input  logic               reset,
    sram_ctrl_if.slave         host,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [DW-1:0]      SRAM_DATA,
    output logic               SRAM_WE_n,
    output logic               SRAM_OE_n
);

    localparam logic [WS_W-1:0] WS_LOAD =
        WS_W'(strobe_len(WAIT_STATES) - 1);

    state_t          state;
    logic [WS_W-1:0] cnt;
    logic            we_q;
    logic            wr_q;
    logic            drive;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   douta_q;
    logic            ack_q;
    logic            busy_q;
    logic            wr_ok;

    // A protected write keeps full timing but never touches the pins.
`ifdef SRAM_CTRL_WP_EN
    assign wr_ok = ~host.wp;
`else
    logic unused_wp;
    assign unused_wp = host.wp;
    assign wr_ok     = 1'b1;
`endif

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            wr_q      <= 1'b0;
            drive     <= 1'b0;
            wdata     <= '0;
            douta_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_WE_n <= 1'b1;
            SRAM_OE_n <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (host.req) begin
                        we_q      <= host.wea;
                        wr_q      <= host.wea & wr_ok;
                        wdata     <= host.dina;
                        SRAM_ADDR <= {PAGE, host.addra};
                        busy_q    <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    cnt   <= WS_LOAD;
                    state <= STROBE;
                    if (!we_q) begin
                        SRAM_OE_n <= 1'b0;
                    end else if (wr_q) begin
                        SRAM_WE_n <= 1'b0;
                        drive     <= 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!we_q) begin
                            douta_q <= SRAM_DATA;
                        end
                        SRAM_OE_n <= 1'b1;
                        SRAM_WE_n <= 1'b1;
                        ack_q     <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // Data and address outlive WE_n by this cycle.
                    ack_q  <= 1'b0;
                    drive  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SRAM_DATA  = drive ? wdata : {DW{1'bz}};
    assign host.douta = douta_q;
    assign host.ack   = ack_q;
    assign host.busy  = busy_q;

endmodule
